// File: rtl/lock_access_controller_pkg.sv
// rtl/lock_access_controller_pkg.sv - shared state encodings and helpers for the lock access controller
package lock_access_controller_pkg;

  // 3-bit encodings, kept stable so lock-core monitors can decode the state
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  // Largest of three cycle counts, used to size the shared timer
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lock_ctrl_timer.sv
// rtl/lock_ctrl_timer.sv - loadable down-counter with zero flag, stops at zero
module lock_ctrl_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // Load wins over counting; the counter parks at zero instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/lock_access_controller.sv
// rtl/lock_access_controller.sv - press forwarding, entry timeout, door hold and lockout sequencing
module lock_access_controller
  import lock_access_controller_pkg::*;
#(
  parameter int ENTRY_TIMEOUT  = 16,
  parameter int OPEN_CYCLES    = 8,
  parameter int LOCKOUT_CYCLES = 32,
  parameter int MAX_FAILS      = 3,
  localparam int FAIL_W        = $clog2(MAX_FAILS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_0_in,
  input  logic              btn_1_in,
  input  logic              lock_unlock,
  output logic              btn_0_out,
  output logic              btn_1_out,
  output logic              lock_clear,
  output logic              door_open,
  output logic              locked_out,
  output logic [FAIL_W-1:0] fail_count
);

  localparam int TIMER_MAX = max3(ENTRY_TIMEOUT, OPEN_CYCLES, LOCKOUT_CYCLES);
  localparam int TIMER_W   = $clog2(TIMER_MAX);

  state_e              state_q;
  logic                btn_0_q;
  logic                btn_1_q;
  logic                lock_clear_q;
  logic                door_open_q;
  logic                locked_out_q;
  logic [FAIL_W-1:0]   fail_count_q;

  logic                press;
  logic                idle_press;
  logic                entry_unlock;
  logic                entry_press;
  logic                entry_fail;
  logic [FAIL_W-1:0]   fail_inc;
  logic                lockout_hit;
  logic                timer_load;
  logic [TIMER_W-1:0]  timer_val;
  logic                timer_zero;

  assign press        = btn_0_in | btn_1_in;
  assign idle_press   = (state_q == ST_IDLE) & press;
  assign entry_unlock = (state_q == ST_ENTRY) & lock_unlock;
  assign entry_press  = (state_q == ST_ENTRY) & ~lock_unlock & press;
  assign entry_fail   = (state_q == ST_ENTRY) & ~lock_unlock & ~press & timer_zero;

  assign fail_inc     = (fail_count_q == FAIL_W'(MAX_FAILS)) ? fail_count_q
                                                             : fail_count_q + 1'b1;
  assign lockout_hit  = (fail_inc == FAIL_W'(MAX_FAILS));

  // Timer reloads only on entry to a timed state or on an accepted press
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    if (idle_press || entry_press) begin
      timer_load = 1'b1;
      timer_val  = TIMER_W'(ENTRY_TIMEOUT - 1);
    end else if (entry_unlock) begin
      timer_load = 1'b1;
      timer_val  = TIMER_W'(OPEN_CYCLES - 1);
    end else if (entry_fail && lockout_hit) begin
      timer_load = 1'b1;
      timer_val  = TIMER_W'(LOCKOUT_CYCLES - 1);
    end
  end

  lock_ctrl_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .zero_o     (timer_zero)
  );

  // Sequencing FSM with registered outputs; forwarded presses last one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      btn_0_q      <= 1'b0;
      btn_1_q      <= 1'b0;
      lock_clear_q <= 1'b0;
      door_open_q  <= 1'b0;
      locked_out_q <= 1'b0;
      fail_count_q <= '0;
    end else begin
      btn_0_q <= 1'b0;
      btn_1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          lock_clear_q <= 1'b0;
          if (press) begin
            btn_0_q <= btn_0_in;
            btn_1_q <= btn_1_in & ~btn_0_in;
            state_q <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (lock_unlock) begin
            state_q      <= ST_OPEN;
            fail_count_q <= '0;
            door_open_q  <= 1'b1;
          end else if (press) begin
            btn_0_q <= btn_0_in;
            btn_1_q <= btn_1_in & ~btn_0_in;
          end else if (timer_zero) begin
            fail_count_q <= fail_inc;
            lock_clear_q <= 1'b1;
            if (lockout_hit) begin
              state_q      <= ST_LOCKOUT;
              locked_out_q <= 1'b1;
            end else begin
              state_q <= ST_CLEAR;
            end
          end
        end
        ST_OPEN: begin
          if (timer_zero) begin
            door_open_q  <= 1'b0;
            lock_clear_q <= 1'b1;
            state_q      <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          lock_clear_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        ST_LOCKOUT: begin
          if (timer_zero) begin
            fail_count_q <= '0;
            locked_out_q <= 1'b0;
            lock_clear_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          lock_clear_q <= 1'b0;
          door_open_q  <= 1'b0;
          locked_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn_0_out  = btn_0_q;
  assign btn_1_out  = btn_1_q;
  assign lock_clear = lock_clear_q;
  assign door_open  = door_open_q;
  assign locked_out = locked_out_q;
  assign fail_count = fail_count_q;

endmodule
